// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the N-pulse NMR transmit/record sequencer.
package pulse_seq_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PULSE    = 3'd1,
      GAP      = 3'd2,
      REC      = 3'd3,
      REP_WAIT = 3'd4
   } seq_state_e;

   localparam int unsigned DEFAULT_TICK_NS = 5;
   localparam int unsigned DEFAULT_PHASE_W = 2;
   localparam int unsigned FIELD_BUS_W     = 1024;
   localparam int unsigned FIELD_MAX_W     = 64;

   // Field k (w bits wide) of a flattened bus; callers zero-extend the bus and truncate the result.
   function automatic logic [FIELD_MAX_W-1:0] field_of(input logic [FIELD_BUS_W-1:0] bus,
                                                       input int unsigned k,
                                                       input int unsigned w);
      logic [FIELD_MAX_W-1:0] mask;
      mask = (w >= FIELD_MAX_W) ? {FIELD_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
      return FIELD_MAX_W'(bus >> (k * w)) & mask;
   endfunction

endpackage

// File: rtl/seg_timer.sv
// Nanosecond segment timer: counts TICK_NS per cycle, flags the final cycle of a segment.
module seg_timer import pulse_seq_pkg::*; #(
   parameter int unsigned TW      = 32,
   parameter int unsigned TICK_NS = DEFAULT_TICK_NS
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [TW-1:0] len,
   output logic          last
);

   logic [TW:0] acc_r;
   logic [TW:0] acc_next_s;

   // End-of-segment compare; a zero length ends on the very first cycle.
   always_comb begin
      acc_next_s = acc_r + (TW+1)'(TICK_NS);
      last       = (acc_next_s >= {1'b0, len});
   end

   // Accumulator holds once the segment has ended so it can never wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r <= '0;
      end else if (load) begin
         acc_r <= '0;
      end else if (!last) begin
         acc_r <= acc_next_s;
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: rtl/pulse_sequencer.sv
// N-pulse transmit/record sequencer: P0,G0..P(N-1), record window, repetition delay, per shot.
module pulse_sequencer import pulse_seq_pkg::*; #(
   parameter int unsigned N_PULSES = 3,
   parameter int unsigned TW       = 32,
   parameter int unsigned PHASE_W  = DEFAULT_PHASE_W,
   parameter int unsigned SHOT_W   = 16,
   parameter int unsigned TICK_NS  = DEFAULT_TICK_NS
) (
   input  logic                                           clk,
   input  logic                                           reset_n,
   input  logic                                           run,
   input  logic [N_PULSES*TW-1:0]                         pulse_len,
   input  logic [((N_PULSES > 1) ? N_PULSES-1 : 1)*TW-1:0] gap_len,
   input  logic [N_PULSES*PHASE_W-1:0]                    pulse_phase,
   input  logic [TW-1:0]                                  rec_len,
   input  logic [TW-1:0]                                  rep_delay,
   input  logic [SHOT_W-1:0]                              n_shots,
   output logic [PHASE_W-1:0]                             TX_active_phase,
   output logic                                           amp_enable,
   output logic                                           ADC_enable,
   output logic                                           busy,
   output logic [SHOT_W-1:0]                              shot_count,
   output logic                                           done
);

   localparam int unsigned GAP_N = (N_PULSES > 1) ? N_PULSES - 1 : 1;
   localparam int unsigned IDX_W = (N_PULSES > 1) ? $clog2(N_PULSES) : 1;

   seq_state_e                  state_r;
   logic [IDX_W-1:0]            idx_r;
   logic                        run_low_r;
   logic [N_PULSES*TW-1:0]      pulse_len_r;
   logic [GAP_N*TW-1:0]         gap_len_r;
   logic [N_PULSES*PHASE_W-1:0] pulse_phase_r;
   logic [TW-1:0]               rec_len_r;
   logic [TW-1:0]               rep_delay_r;
   logic [SHOT_W-1:0]           n_shots_r;

   logic                        start_s;
   logic                        load_s;
   logic                        last_s;
   logic [TW-1:0]               cur_len_s;
   logic [IDX_W-1:0]            next_idx_s;
   logic [TW-1:0]               next_len_s;
   logic [PHASE_W-1:0]          next_phase_s;
   logic [SHOT_W:0]             shot_inc_s;
   logic                        final_shot_s;

   // Start detect, current segment length and next-pulse lookups from the shadow copy.
   always_comb begin
      start_s      = (state_r == IDLE) && run && run_low_r;
      load_s       = start_s || ((state_r != IDLE) && last_s);
      next_idx_s   = idx_r + IDX_W'(1);
      next_len_s   = TW'(field_of(FIELD_BUS_W'(pulse_len_r), 32'(next_idx_s), TW));
      next_phase_s = PHASE_W'(field_of(FIELD_BUS_W'(pulse_phase_r), 32'(next_idx_s), PHASE_W));
      shot_inc_s   = {1'b0, shot_count} + (SHOT_W+1)'(1);
      final_shot_s = (n_shots_r != '0) && (shot_inc_s == {1'b0, n_shots_r});
      cur_len_s    = '0;
      case (state_r)
         PULSE:    cur_len_s = TW'(field_of(FIELD_BUS_W'(pulse_len_r), 32'(idx_r), TW));
         GAP:      cur_len_s = TW'(field_of(FIELD_BUS_W'(gap_len_r), 32'(idx_r), TW));
         REC:      cur_len_s = rec_len_r;
         REP_WAIT: cur_len_s = rep_delay_r;
         default:  cur_len_s = '0;
      endcase
   end

   seg_timer #(.TW(TW), .TICK_NS(TICK_NS)) u_seg_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_s),
      .len     (cur_len_s),
      .last    (last_s)
   );

   // Sequencer FSM with registered outputs; run_low_r resets to 0 so a run held high through reset cannot start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= IDLE;
         idx_r           <= '0;
         run_low_r       <= 1'b0;
         pulse_len_r     <= '0;
         gap_len_r       <= '0;
         pulse_phase_r   <= '0;
         rec_len_r       <= '0;
         rep_delay_r     <= '0;
         n_shots_r       <= '0;
         TX_active_phase <= '0;
         amp_enable      <= 1'b0;
         ADC_enable      <= 1'b0;
         busy            <= 1'b0;
         shot_count      <= '0;
         done            <= 1'b0;
      end else begin
         run_low_r <= ~run;
         done      <= 1'b0;
         if (state_r == IDLE) begin
            if (start_s) begin
               pulse_len_r     <= pulse_len;
               gap_len_r       <= gap_len;
               pulse_phase_r   <= pulse_phase;
               rec_len_r       <= rec_len;
               rep_delay_r     <= rep_delay;
               n_shots_r       <= n_shots;
               shot_count      <= '0;
               idx_r           <= '0;
               state_r         <= PULSE;
               busy            <= 1'b1;
               amp_enable      <= (pulse_len[TW-1:0] != '0);
               ADC_enable      <= 1'b0;
               TX_active_phase <= pulse_phase[PHASE_W-1:0];
            end else begin
               busy            <= 1'b0;
               amp_enable      <= 1'b0;
               ADC_enable      <= 1'b0;
               TX_active_phase <= '0;
            end
         end else if (!run) begin
            state_r         <= IDLE;
            idx_r           <= '0;
            busy            <= 1'b0;
            amp_enable      <= 1'b0;
            ADC_enable      <= 1'b0;
            TX_active_phase <= '0;
         end else if (last_s) begin
            case (state_r)
               PULSE: begin
                  amp_enable <= 1'b0;
                  if (idx_r == IDX_W'(N_PULSES - 1)) begin
                     state_r    <= REC;
                     ADC_enable <= 1'b1;
                  end else begin
                     state_r    <= GAP;
                     ADC_enable <= 1'b0;
                  end
               end
               GAP: begin
                  state_r         <= PULSE;
                  idx_r           <= next_idx_s;
                  amp_enable      <= (next_len_s != '0);
                  TX_active_phase <= next_phase_s;
               end
               REC: begin
                  ADC_enable <= 1'b0;
                  shot_count <= (&shot_count) ? shot_count : shot_inc_s[SHOT_W-1:0];
                  if (final_shot_s) begin
                     state_r         <= IDLE;
                     idx_r           <= '0;
                     busy            <= 1'b0;
                     done            <= 1'b1;
                     TX_active_phase <= '0;
                  end else begin
                     state_r <= REP_WAIT;
                  end
               end
               REP_WAIT: begin
                  state_r         <= PULSE;
                  idx_r           <= '0;
                  amp_enable      <= (pulse_len_r[TW-1:0] != '0);
                  TX_active_phase <= pulse_phase_r[PHASE_W-1:0];
               end
               default: begin
                  state_r         <= IDLE;
                  idx_r           <= '0;
                  busy            <= 1'b0;
                  amp_enable      <= 1'b0;
                  ADC_enable      <= 1'b0;
                  TX_active_phase <= '0;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench: expected output segments queued per run, a negedge monitor compares them.
module tb_pulse_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        run;
   logic [95:0] pulse_len;
   logic [63:0] gap_len;
   logic [5:0]  pulse_phase;
   logic [31:0] rec_len;
   logic [31:0] rep_delay;
   logic [15:0] n_shots;
   logic [1:0]  TX_active_phase;
   logic        amp_enable;
   logic        ADC_enable;
   logic        busy;
   logic [15:0] shot_count;
   logic        done;

   typedef struct packed {
      logic        is_done;
      logic        amp;
      logic        adc;
      logic [1:0]  ph;
      logic [31:0] dur;
      logic [15:0] sc;
   } ev_t;

   ev_t  sb[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   pulse_sequencer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .run             (run),
      .pulse_len       (pulse_len),
      .gap_len         (gap_len),
      .pulse_phase     (pulse_phase),
      .rec_len         (rec_len),
      .rep_delay       (rep_delay),
      .n_shots         (n_shots),
      .TX_active_phase (TX_active_phase),
      .amp_enable      (amp_enable),
      .ADC_enable      (ADC_enable),
      .busy            (busy),
      .shot_count      (shot_count),
      .done            (done)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic exp_seg(input logic amp, input logic adc, input logic [1:0] ph,
                          input int dur, input logic [15:0] sc);
      ev_t e;
      e.is_done = 1'b0; e.amp = amp; e.adc = adc; e.ph = ph; e.dur = dur; e.sc = sc;
      sb.push_back(e);
   endtask

   task automatic exp_done(input logic [15:0] sc);
      ev_t e;
      e.is_done = 1'b1; e.amp = 1'b0; e.adc = 1'b0; e.ph = 2'd0; e.dur = 32'd0; e.sc = sc;
      sb.push_back(e);
   endtask

   task automatic sb_check(input ev_t act);
      ev_t exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL event_unexpected actual done=%0b amp=%0b adc=%0b ph=%0d dur=%0d sc=%0d required=none",
                  act.is_done, act.amp, act.adc, act.ph, act.dur, act.sc);
      end else begin
         exp = sb.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL event actual done=%0b amp=%0b adc=%0b ph=%0d dur=%0d sc=%0d required done=%0b amp=%0b adc=%0b ph=%0d dur=%0d sc=%0d",
                     act.is_done, act.amp, act.adc, act.ph, act.dur, act.sc,
                     exp.is_done, exp.amp, exp.adc, exp.ph, exp.dur, exp.sc);
         end
      end
   endtask

   // Monitor: collapses busy cycles into constant-output segments and reports done strobes.
   initial begin : monitor
      logic [4:0] sig_now;
      logic [4:0] cur_sig;
      int         cur_dur;
      bit         have_seg;
      ev_t        e;
      have_seg = 1'b0;
      cur_dur  = 0;
      cur_sig  = 5'd0;
      forever begin
         @(negedge clk);
         sig_now = {busy, amp_enable, ADC_enable, TX_active_phase};
         if (!mon_en) begin
            have_seg = 1'b0;
         end else begin
            chk("amp_adc_exclusive", 64'(amp_enable & ADC_enable), 64'd0);
            if (have_seg && sig_now == cur_sig) begin
               cur_dur++;
            end else begin
               if (have_seg) begin
                  e.is_done = 1'b0; e.amp = cur_sig[3]; e.adc = cur_sig[2];
                  e.ph = cur_sig[1:0]; e.dur = cur_dur; e.sc = shot_count;
                  sb_check(e);
               end
               have_seg = busy;
               cur_sig  = sig_now;
               cur_dur  = 1;
            end
            if (done) begin
               e.is_done = 1'b1; e.amp = 1'b0; e.adc = 1'b0; e.ph = 2'd0; e.dur = 32'd0; e.sc = shot_count;
               sb_check(e);
            end
         end
      end
   end

   task automatic set_cfg(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] g0, input logic [31:0] g1,
                          input logic [31:0] rl, input logic [31:0] rd,
                          input logic [1:0] ph0, input logic [1:0] ph1, input logic [1:0] ph2,
                          input logic [15:0] ns);
      pulse_len   = {p2, p1, p0};
      gap_len     = {g1, g0};
      pulse_phase = {ph2, ph1, ph0};
      rec_len     = rl;
      rep_delay   = rd;
      n_shots     = ns;
   endtask

   task automatic start_run(input logic amp0, input logic [1:0] ph0);
      @(posedge clk); #1 run = 1'b1;
      @(negedge clk);
      chk("start_cycle0_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_amp", 64'(amp_enable), 64'(amp0));
      chk("start_phase", 64'(TX_active_phase), 64'(ph0));
      chk("start_shot_count", 64'(shot_count), 64'd0);
   endtask

   task automatic stop_run();
      @(posedge clk); #1 run = 1'b0;
      @(posedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_within_budget", 64'(busy === 1'b0), 64'd1);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      run     = 1'b0;
      set_cfg(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 2'd0, 16'd0);
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_amp", 64'(amp_enable), 64'd0);
      chk("reset_adc", 64'(ADC_enable), 64'd0);
      chk("reset_phase", 64'(TX_active_phase), 64'd0);
      chk("reset_shot_count", 64'(shot_count), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      reset_n = 1'b1;
      #1 mon_en = 1'b1;

      // Three-pulse reference shot
      set_cfg(32'd100, 32'd200, 32'd100, 32'd500, 32'd300, 32'd1000, 32'd0, 2'd0, 2'd1, 2'd2, 16'd1);
      exp_seg(1'b1, 1'b0, 2'd0, 20, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd0, 100, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd1, 40, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd1, 60, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd2, 20, 16'd0);
      exp_seg(1'b0, 1'b1, 2'd2, 200, 16'd1);
      exp_done(16'd1);
      start_run(1'b1, 2'd0);
      wait_idle(600);
      stop_run();

      // Non-multiple and zero-length pulses (zero pulse merges with the following gap)
      set_cfg(32'd12, 32'd0, 32'd20, 32'd50, 32'd50, 32'd25, 32'd0, 2'd1, 2'd2, 2'd3, 16'd1);
      exp_seg(1'b1, 1'b0, 2'd1, 3, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd1, 10, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd2, 11, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd3, 4, 16'd0);
      exp_seg(1'b0, 1'b1, 2'd3, 5, 16'd1);
      exp_done(16'd1);
      start_run(1'b1, 2'd1);
      wait_idle(100);
      stop_run();

      // Three shots with 10-cycle repetition delay, single done
      set_cfg(32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd20, 32'd50, 2'd0, 2'd1, 2'd2, 16'd3);
      for (int s = 1; s <= 3; s++) begin
         exp_seg(1'b1, 1'b0, 2'd0, 2, 16'(s - 1));
         exp_seg(1'b0, 1'b0, 2'd0, 2, 16'(s - 1));
         exp_seg(1'b1, 1'b0, 2'd1, 2, 16'(s - 1));
         exp_seg(1'b0, 1'b0, 2'd1, 2, 16'(s - 1));
         exp_seg(1'b1, 1'b0, 2'd2, 2, 16'(s - 1));
         exp_seg(1'b0, 1'b1, 2'd2, 4, 16'(s));
         if (s < 3) exp_seg(1'b0, 1'b0, 2'd2, 10, 16'(s));
      end
      exp_done(16'd3);
      start_run(1'b1, 2'd0);
      wait_idle(200);
      stop_run();

      // Continuous mode, aborted during PULSE 1 of the third shot
      set_cfg(32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd20, 32'd50, 2'd0, 2'd1, 2'd2, 16'd0);
      for (int s = 1; s <= 2; s++) begin
         exp_seg(1'b1, 1'b0, 2'd0, 2, 16'(s - 1));
         exp_seg(1'b0, 1'b0, 2'd0, 2, 16'(s - 1));
         exp_seg(1'b1, 1'b0, 2'd1, 2, 16'(s - 1));
         exp_seg(1'b0, 1'b0, 2'd1, 2, 16'(s - 1));
         exp_seg(1'b1, 1'b0, 2'd2, 2, 16'(s - 1));
         exp_seg(1'b0, 1'b1, 2'd2, 4, 16'(s));
         exp_seg(1'b0, 1'b0, 2'd2, 10, 16'(s));
      end
      exp_seg(1'b1, 1'b0, 2'd0, 2, 16'd2);
      exp_seg(1'b0, 1'b0, 2'd0, 2, 16'd2);
      exp_seg(1'b1, 1'b0, 2'd1, 1, 16'd2);
      start_run(1'b1, 2'd0);
      repeat (52) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_amp", 64'(amp_enable), 64'd0);
      chk("abort_adc", 64'(ADC_enable), 64'd0);
      chk("abort_phase", 64'(TX_active_phase), 64'd0);
      chk("abort_shot_count", 64'(shot_count), 64'd2);
      chk("abort_done", 64'(done), 64'd0);
      wait_idle(10);

      // Asynchronous reset during REC; run held high afterwards must not restart
      set_cfg(32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd20, 32'd0, 2'd0, 2'd1, 2'd2, 16'd1);
      exp_seg(1'b1, 1'b0, 2'd0, 2, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd0, 2, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd1, 2, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd1, 2, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd2, 2, 16'd0);
      start_run(1'b1, 2'd0);
      repeat (11) @(negedge clk);
      chk("pre_reset_adc", 64'(ADC_enable), 64'd1);
      #1 mon_en = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_adc", 64'(ADC_enable), 64'd0);
      chk("async_reset_amp", 64'(amp_enable), 64'd0);
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk("async_reset_phase", 64'(TX_active_phase), 64'd0);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_start_run_held", 64'(busy), 64'd0);
      chk("no_start_amp", 64'(amp_enable), 64'd0);
      #1 mon_en = 1'b1;
      stop_run();

      // Config change mid-shot ignored; next run picks up the new values
      exp_seg(1'b1, 1'b0, 2'd0, 2, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd0, 2, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd1, 2, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd1, 2, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd2, 2, 16'd0);
      exp_seg(1'b0, 1'b1, 2'd2, 4, 16'd1);
      exp_done(16'd1);
      start_run(1'b1, 2'd0);
      repeat (4) @(negedge clk);
      set_cfg(32'd15, 32'd5, 32'd25, 32'd5, 32'd40, 32'd7, 32'd0, 2'd3, 2'd0, 2'd1, 16'd1);
      wait_idle(100);
      stop_run();
      exp_seg(1'b1, 1'b0, 2'd3, 3, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd3, 1, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd0, 1, 16'd0);
      exp_seg(1'b0, 1'b0, 2'd0, 8, 16'd0);
      exp_seg(1'b1, 1'b0, 2'd1, 5, 16'd0);
      exp_seg(1'b0, 1'b1, 2'd1, 2, 16'd1);
      exp_done(16'd1);
      start_run(1'b1, 2'd3);
      wait_idle(100);
      stop_run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
